// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encodings, default array size and drain-length helper
// for the matmul sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int MAT_SIZE_DEFAULT = 4;

    // The array skews data by one cycle per row and column, so the last partial
    // sum leaves the array 2*M-1 cycles after the last operand enters.
    function automatic int drain_len(input int m);
        return 2 * m - 1;
    endfunction

endpackage

// File: rtl/matmul_sequencer_step_counter.sv
// step_counter: loadable down-counter with a terminal-count flag used to time
// one sequencer phase.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   i_load      - load i_value (takes priority over counting)
//   i_value     - phase length in cycles
//   o_tc        - high during the last cycle of the loaded phase
module step_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: start/done responder that sequences one tile multiply
// (operand reads, array drain, result writes) on the systolic array.
// Optional feature: define MATMUL_SEQ_PERF_EN to add the busy_cycles counter.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   start_mat_mul              - level request from the top-level controller
//   k_dim                      - accumulation depth, sampled on acceptance
//   a_base, b_base, c_base     - SRAM base addresses, sampled on acceptance
//   a_rd_en/a_addr, b_rd_en/b_addr - operand SRAM reads
//   c_wr_en/c_addr             - result SRAM writes
//   done_mat_mul               - completion level, held until start drops
//   busy_cycles                - clocks spent in FEED/DRAIN/WRITE (perf build only)
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int MAT_SIZE = MAT_SIZE_DEFAULT,
    parameter int AWIDTH   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mat_mul,
    input  logic [7:0]        k_dim,
    input  logic [AWIDTH-1:0] a_base,
    input  logic [AWIDTH-1:0] b_base,
    input  logic [AWIDTH-1:0] c_base,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [AWIDTH-1:0] a_addr,
    output logic [AWIDTH-1:0] b_addr,
    output logic              c_wr_en,
    output logic [AWIDTH-1:0] c_addr,
    output logic              done_mat_mul
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [15:0]       busy_cycles
`endif
);

    localparam int CW = 16;

    state_t            r_state;
    state_t            w_next;
    logic              w_load;
    logic [CW-1:0]     w_load_val;
    logic              w_tc;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [AWIDTH-1:0] w_a_addr;
    logic [AWIDTH-1:0] w_b_addr;
    logic [AWIDTH-1:0] w_c_addr;
    logic [AWIDTH-1:0] r_c_base;

    step_counter #(.W(CW)) u_step (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE:
                if (start_mat_mul) begin
                    w_next     = (k_dim == 8'd0) ? ST_DONE : ST_FEED;
                    w_load     = 1'b1;
                    w_load_val = CW'(k_dim);
                end
            ST_FEED:
                if (!start_mat_mul)
                    w_next = ST_IDLE;
                else if (w_tc) begin
                    w_next     = ST_DRAIN;
                    w_load     = 1'b1;
                    w_load_val = CW'(drain_len(MAT_SIZE));
                end
            ST_DRAIN:
                if (!start_mat_mul)
                    w_next = ST_IDLE;
                else if (w_tc) begin
                    w_next     = ST_WRITE;
                    w_load     = 1'b1;
                    w_load_val = CW'(MAT_SIZE);
                end
            ST_WRITE:
                if (!start_mat_mul)
                    w_next = ST_IDLE;
                else if (w_tc)
                    w_next = ST_DONE;
            ST_DONE:
                if (!start_mat_mul)
                    w_next = ST_IDLE;
            default:
                w_next = ST_IDLE;
        endcase
        w_accept = (r_state == ST_IDLE) && start_mat_mul;
        w_rd_en  = (w_next == ST_FEED);
        w_wr_en  = (w_next == ST_WRITE);
        // The address registers themselves hold base+cnt, so the A/B bases are
        // captured by loading them on acceptance and the counters step from there.
        w_a_addr = !w_rd_en ? '0 : w_accept ? a_base : a_addr + 1'b1;
        w_b_addr = !w_rd_en ? '0 : w_accept ? b_base : b_addr + 1'b1;
        w_c_addr = !w_wr_en ? '0 : (r_state == ST_DRAIN) ? r_c_base : c_addr + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_c_base     <= '0;
            a_rd_en      <= 1'b0;
            b_rd_en      <= 1'b0;
            a_addr       <= '0;
            b_addr       <= '0;
            c_wr_en      <= 1'b0;
            c_addr       <= '0;
            done_mat_mul <= 1'b0;
        end else begin
            r_state      <= w_next;
            if (w_accept)
                r_c_base <= c_base;
            a_rd_en      <= w_rd_en;
            b_rd_en      <= w_rd_en;
            a_addr       <= w_a_addr;
            b_addr       <= w_b_addr;
            c_wr_en      <= w_wr_en;
            c_addr       <= w_c_addr;
            done_mat_mul <= (w_next == ST_DONE);
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_cycles <= '0;
        else if (w_accept)
            busy_cycles <= '0;
        else if ((r_state == ST_FEED || r_state == ST_DRAIN || r_state == ST_WRITE) &&
                 busy_cycles != 16'hFFFF)
            busy_cycles <= busy_cycles + 1'b1;
    end
`endif

endmodule
